// File: rtl/ds_format_lsu_sequencer.sv
// DS-format load/store sequencer: RA read -> EA -> RS read(s) -> 64-bit access(es) -> RT/RA writeback.
// Latency: 5+ cycles per op, stretched by memAck_i; stall_o holds off the decoder whenever not IDLE.
module ds_format_lsu_sequencer #(
  parameter int regWidth  = 5,
  parameter int immWidth  = 14,
  parameter int dataWidth = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [2:0]           op_i,
  input  logic [regWidth-1:0]  reg1_i,
  input  logic [regWidth-1:0]  reg2_i,
  input  logic                 reg2ValOrZero_i,
  input  logic [immWidth-1:0]  imm_i,
  output logic                 stall_o,
  output logic                 invalid_o,
  output logic                 misaligned_o,
  output logic                 rfReadEn_o,
  output logic [regWidth-1:0]  rfReadAddr_o,
  input  logic [dataWidth-1:0] rfReadData_i,
  output logic                 memReq_o,
  output logic                 memWrite_o,
  output logic [1:0]           memSize_o,
  output logic [dataWidth-1:0] memAddr_o,
  output logic [dataWidth-1:0] memWData_o,
  input  logic                 memAck_i,
  input  logic [dataWidth-1:0] memRData_i,
  output logic                 wbEn_o,
  output logic [regWidth-1:0]  wbReg_o,
  output logic [dataWidth-1:0] wbData_o
);

  localparam logic [3:0] IDLE = 4'd0, RD_RA = 4'd1, ADDR = 4'd2, RD_RS1 = 4'd3, DATA1 = 4'd4,
                         MEM0 = 4'd5, MEM1 = 4'd6, WB_RT = 4'd7, WB_RA = 4'd8;

  localparam logic [2:0] OP_LD = 3'd0, OP_LDU = 3'd1, OP_LWA = 3'd2,
                         OP_STDU = 3'd5, OP_STQ = 3'd6;

  typedef struct packed {
    logic [2:0]          op;
    logic [regWidth-1:0] rt;
    logic [regWidth-1:0] ra;
    logic                zero_base;
    logic [immWidth-1:0] imm;
  } op_fields_t;

  logic [3:0]           state;
  op_fields_t           cur;
  logic [dataWidth-1:0] ea, wdata0, wdata1;
  logic                 form_bad;
  logic                 is_store, is_stq, is_load;
  logic [dataWidth-1:0] base, ea_next, load_data;

  always_comb begin
    form_bad = (op_i == 3'd3) || (op_i == 3'd7)
            || ((op_i == OP_LDU || op_i == OP_STDU) && reg2_i == '0)
            || (op_i == OP_LDU && reg2_i == reg1_i)
            || (op_i == OP_STQ && reg1_i[0]);
  end

  assign is_store  = cur.op[2];
  assign is_stq    = (cur.op == OP_STQ);
  assign is_load   = !cur.op[2];
  assign base      = (cur.zero_base && cur.ra == '0) ? '0 : rfReadData_i;
  assign ea_next   = base + {{(dataWidth-immWidth-2){cur.imm[immWidth-1]}}, cur.imm, 2'b00};
  // LWA: word lives in the low 32 bits and is sign-extended
  assign load_data = (cur.op == OP_LWA) ? {{(dataWidth-32){memRData_i[31]}}, memRData_i[31:0]}
                                        : memRData_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cur          <= '0;
      ea           <= '0;
      wdata0       <= '0;
      wdata1       <= '0;
      stall_o      <= 1'b0;
      invalid_o    <= 1'b0;
      misaligned_o <= 1'b0;
      rfReadEn_o   <= 1'b0;
      rfReadAddr_o <= '0;
      memReq_o     <= 1'b0;
      memWrite_o   <= 1'b0;
      memSize_o    <= 2'd0;
      memAddr_o    <= '0;
      memWData_o   <= '0;
      wbEn_o       <= 1'b0;
      wbReg_o      <= '0;
      wbData_o     <= '0;
    end else begin
      invalid_o    <= 1'b0;
      misaligned_o <= 1'b0;
      rfReadEn_o   <= 1'b0;
      wbEn_o       <= 1'b0;
      case (state)
        IDLE: if (enable_i) begin
          cur <= '{op: op_i, rt: reg1_i, ra: reg2_i, zero_base: reg2ValOrZero_i, imm: imm_i};
          if (form_bad) begin
            invalid_o <= 1'b1;
          end else begin
            stall_o      <= 1'b1;
            state        <= RD_RA;
            rfReadEn_o   <= !(reg2ValOrZero_i && reg2_i == '0);
            rfReadAddr_o <= reg2_i;
          end
        end
        RD_RA: begin
          // read of RS overlaps EA formation; its data lands in DATA1
          rfReadEn_o   <= is_store;
          rfReadAddr_o <= cur.rt;
          state        <= ADDR;
        end
        ADDR: begin
          ea <= ea_next;
          if (is_stq && ea_next[3:0] != 4'd0) begin
            misaligned_o <= 1'b1;
            stall_o      <= 1'b0;
            state        <= IDLE;
          end else if (is_store) begin
            rfReadEn_o   <= is_stq;
            rfReadAddr_o <= {cur.rt[regWidth-1:1], 1'b1};
            state        <= DATA1;
          end else begin
            memReq_o   <= 1'b1;
            memWrite_o <= 1'b0;
            memSize_o  <= (cur.op == OP_LWA) ? 2'd2 : 2'd3;
            memAddr_o  <= ea_next;
            memWData_o <= '0;
            state      <= MEM0;
          end
        end
        DATA1: begin
          wdata0 <= rfReadData_i;
          if (is_stq) begin
            state <= RD_RS1;
          end else begin
            memReq_o   <= 1'b1;
            memWrite_o <= 1'b1;
            memSize_o  <= 2'd3;
            memAddr_o  <= ea;
            memWData_o <= rfReadData_i;
            state      <= MEM0;
          end
        end
        RD_RS1: begin
          wdata1     <= rfReadData_i;
          memReq_o   <= 1'b1;
          memWrite_o <= 1'b1;
          memSize_o  <= 2'd3;
          memAddr_o  <= ea;
          memWData_o <= wdata0;
          state      <= MEM0;
        end
        MEM0: if (memAck_i) begin
          memReq_o <= 1'b0;
          if (is_load) begin
            wbEn_o   <= 1'b1;
            wbReg_o  <= cur.rt;
            wbData_o <= load_data;
            state    <= WB_RT;
          end else if (is_stq) begin
            state <= MEM1;
          end else if (cur.op == OP_STDU) begin
            wbEn_o   <= 1'b1;
            wbReg_o  <= cur.ra;
            wbData_o <= ea;
            state    <= WB_RA;
          end else begin
            stall_o <= 1'b0;
            state   <= IDLE;
          end
        end
        MEM1: begin
          // request is low for one cycle between the two quad halves
          if (!memReq_o) begin
            memReq_o   <= 1'b1;
            memAddr_o  <= ea + dataWidth'(8);
            memWData_o <= wdata1;
          end else if (memAck_i) begin
            memReq_o <= 1'b0;
            stall_o  <= 1'b0;
            state    <= IDLE;
          end
        end
        WB_RT: begin
          if (cur.op == OP_LDU) begin
            wbEn_o   <= 1'b1;
            wbReg_o  <= cur.ra;
            wbData_o <= ea;
            state    <= WB_RA;
          end else begin
            stall_o <= 1'b0;
            state   <= IDLE;
          end
        end
        WB_RA: begin
          stall_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          memReq_o <= 1'b0;
          stall_o  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds_format_lsu_sequencer.sv
// Directed bench for ds_format_lsu_sequencer with a regfile model and a delayed-ack memory model.
module tb_ds_format_lsu_sequencer;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [2:0]  op_i;
  logic [4:0]  reg1_i, reg2_i;
  logic        reg2ValOrZero_i;
  logic [13:0] imm_i;
  logic        stall_o, invalid_o, misaligned_o;
  logic        rfReadEn_o;
  logic [4:0]  rfReadAddr_o;
  logic [63:0] rfReadData_i;
  logic        memReq_o, memWrite_o;
  logic [1:0]  memSize_o;
  logic [63:0] memAddr_o, memWData_o;
  logic        memAck_i;
  logic [63:0] memRData_i;
  logic        wbEn_o;
  logic [4:0]  wbReg_o;
  logic [63:0] wbData_o;

  ds_format_lsu_sequencer dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .op_i(op_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .reg2ValOrZero_i(reg2ValOrZero_i), .imm_i(imm_i),
    .stall_o(stall_o), .invalid_o(invalid_o), .misaligned_o(misaligned_o),
    .rfReadEn_o(rfReadEn_o), .rfReadAddr_o(rfReadAddr_o), .rfReadData_i(rfReadData_i),
    .memReq_o(memReq_o), .memWrite_o(memWrite_o), .memSize_o(memSize_o),
    .memAddr_o(memAddr_o), .memWData_o(memWData_o), .memAck_i(memAck_i),
    .memRData_i(memRData_i), .wbEn_o(wbEn_o), .wbReg_o(wbReg_o), .wbData_o(wbData_o)
  );

  always #5 clock_i = ~clock_i;

  logic [63:0] regs [32];
  logic [63:0] mem_rdata;
  int          ack_delay;
  int          wait_cnt;

  always @(posedge clock_i)
    if (rfReadEn_o) rfReadData_i <= regs[rfReadAddr_o];

  // Memory model: ack arrives in cycle ack_delay+1 of a request.
  logic [63:0] mem_adr [64];
  logic [63:0] mem_wd  [64];
  logic [1:0]  mem_sz  [64];
  logic        mem_wr  [64];
  int          mem_cnt = 0;

  always @(posedge clock_i) begin
    if (reset_i) begin
      memAck_i <= 1'b0;
      wait_cnt <= 0;
    end else if (memReq_o && !memAck_i) begin
      if (wait_cnt >= ack_delay - 1) begin
        memAck_i   <= 1'b1;
        memRData_i <= mem_rdata;
        mem_adr[mem_cnt % 64] = memAddr_o;
        mem_wd[mem_cnt % 64]  = memWData_o;
        mem_sz[mem_cnt % 64]  = memSize_o;
        mem_wr[mem_cnt % 64]  = memWrite_o;
        mem_cnt++;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      memAck_i <= 1'b0;
      wait_cnt <= 0;
    end
  end

  int          stall_cyc = 0, req_cyc = 0, rd_cnt = 0, inv_cnt = 0, mis_cnt = 0, wb_cnt = 0;
  logic [4:0]  wb_reg [64];
  logic [63:0] wb_dat [64];
  logic        wb_stl [64];

  always @(negedge clock_i) begin
    if (stall_o)      stall_cyc++;
    if (memReq_o)     req_cyc++;
    if (rfReadEn_o)   rd_cnt++;
    if (invalid_o)    inv_cnt++;
    if (misaligned_o) mis_cnt++;
    if (wbEn_o) begin
      wb_reg[wb_cnt % 64] = wbReg_o;
      wb_dat[wb_cnt % 64] = wbData_o;
      wb_stl[wb_cnt % 64] = stall_o;
      wb_cnt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int b_stall, b_req, b_rd, b_inv, b_mis, b_wb, b_mem;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_stall = stall_cyc; b_req = req_cyc; b_rd = rd_cnt; b_inv = inv_cnt;
    b_mis = mis_cnt; b_wb = wb_cnt; b_mem = mem_cnt;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic zb, input logic [13:0] imm);
    @(negedge clock_i);
    enable_i = 1'b1; op_i = op; reg1_i = r1; reg2_i = r2; reg2ValOrZero_i = zb; imm_i = imm;
    @(negedge clock_i);
    enable_i = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic zb, input logic [13:0] imm);
    bit done;
    snap();
    issue(op, r1, r2, zb, imm);
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clock_i);
    end
    if (!done) check("op_timeout", 64'd1, 64'd0);
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    bit seen;
    reset_i = 1'b1; enable_i = 1'b0; op_i = '0; reg1_i = '0; reg2_i = '0;
    reg2ValOrZero_i = 1'b0; imm_i = '0; ack_delay = 1; mem_rdata = '0;
    for (int i = 0; i < 32; i++) regs[i] = 64'h0;
    regs[1] = 64'h2000; regs[4] = 64'h1000; regs[6] = 64'hAAAA_0000_0000_0006;
    regs[7] = 64'hBBBB_0000_0000_0007; regs[8] = 64'h300; regs[9] = 64'h55; regs[10] = 64'h100;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(posedge clock_i); #1;
    check("reset_ctrl", {stall_o, invalid_o, misaligned_o, rfReadEn_o, memReq_o, wbEn_o}, 64'd0);
    check("reset_addr", memAddr_o, 64'd0);

    // LD r3,8(r4)
    mem_rdata = 64'hDEAD;
    run_op(3'd0, 5'd3, 5'd4, 1'b0, 14'd2);
    check("ld_mem_count", 64'(mem_cnt - b_mem), 64'd1);
    check("ld_addr", mem_adr[b_mem % 64], 64'h1008);
    check("ld_size_wr", {mem_sz[b_mem % 64], mem_wr[b_mem % 64]}, {2'd3, 1'b0});
    check("ld_rf_reads", 64'(rd_cnt - b_rd), 64'd1);
    check("ld_wb_count", 64'(wb_cnt - b_wb), 64'd1);
    check("ld_wb_reg", 64'(wb_reg[b_wb % 64]), 64'd3);
    check("ld_wb_data", wb_dat[b_wb % 64], 64'hDEAD);
    check("ld_stall_at_wb", 64'(wb_stl[b_wb % 64]), 64'd1);
    check("ld_stall_cycles", 64'(stall_cyc - b_stall), 64'd5);

    // LWA r5,-4(r0) with zero base
    mem_rdata = 64'hABCD_0000_8000_0000;
    run_op(3'd2, 5'd5, 5'd0, 1'b1, 14'h3FFF);
    check("lwa_rf_reads", 64'(rd_cnt - b_rd), 64'd0);
    check("lwa_addr", mem_adr[b_mem % 64], 64'hFFFF_FFFF_FFFF_FFFC);
    check("lwa_size", 64'(mem_sz[b_mem % 64]), 64'd2);
    check("lwa_wb_reg", 64'(wb_reg[b_wb % 64]), 64'd5);
    check("lwa_wb_data", wb_dat[b_wb % 64], 64'hFFFF_FFFF_8000_0000);

    // STQ r6,16(r1), r1=0x2000
    ack_delay = 2;
    run_op(3'd6, 5'd6, 5'd1, 1'b0, 14'd4);
    check("stq_mem_count", 64'(mem_cnt - b_mem), 64'd2);
    check("stq_addr0", mem_adr[b_mem % 64], 64'h2010);
    check("stq_data0", mem_wd[b_mem % 64], 64'hAAAA_0000_0000_0006);
    check("stq_wr0", {mem_sz[b_mem % 64], mem_wr[b_mem % 64]}, {2'd3, 1'b1});
    check("stq_addr1", mem_adr[(b_mem + 1) % 64], 64'h2018);
    check("stq_data1", mem_wd[(b_mem + 1) % 64], 64'hBBBB_0000_0000_0007);
    check("stq_req_cycles", 64'(req_cyc - b_req), 64'd6);
    check("stq_rf_reads", 64'(rd_cnt - b_rd), 64'd3);
    check("stq_no_wb", 64'(wb_cnt - b_wb), 64'd0);

    // STQ misaligned, r1=0x2004
    regs[1] = 64'h2004;
    run_op(3'd6, 5'd6, 5'd1, 1'b0, 14'd4);
    check("stq_mis_pulse", 64'(mis_cnt - b_mis), 64'd1);
    check("stq_mis_no_req", 64'(req_cyc - b_req), 64'd0);

    // Invalid forms
    run_op(3'd1, 5'd2, 5'd2, 1'b0, 14'd2);
    check("ldu_ra_eq_rt_inv", 64'(inv_cnt - b_inv), 64'd1);
    check("ldu_inv_quiet", 64'(rd_cnt - b_rd + req_cyc - b_req + stall_cyc - b_stall), 64'd0);
    run_op(3'd5, 5'd9, 5'd0, 1'b0, 14'd2);
    check("stdu_ra0_inv", 64'(inv_cnt - b_inv), 64'd1);
    check("stdu_inv_quiet", 64'(rd_cnt - b_rd + req_cyc - b_req + stall_cyc - b_stall), 64'd0);
    run_op(3'd3, 5'd1, 5'd2, 1'b0, 14'd0);
    check("op3_inv", 64'(inv_cnt - b_inv), 64'd1);
    run_op(3'd6, 5'd7, 5'd1, 1'b0, 14'd0);
    check("stq_odd_rs_inv", 64'(inv_cnt - b_inv), 64'd1);

    // STDU r9,-8(r10) with 3-cycle ack delay
    ack_delay = 3;
    run_op(3'd5, 5'd9, 5'd10, 1'b0, 14'h3FFE);
    check("stdu_req_cycles", 64'(req_cyc - b_req), 64'd4);
    check("stdu_addr", mem_adr[b_mem % 64], 64'hF8);
    check("stdu_data", mem_wd[b_mem % 64], 64'h55);
    check("stdu_wb_count", 64'(wb_cnt - b_wb), 64'd1);
    check("stdu_wb_reg", 64'(wb_reg[b_wb % 64]), 64'd10);
    check("stdu_wb_data", wb_dat[b_wb % 64], 64'hF8);

    // LDU r4,8(r8): RT then RA
    ack_delay = 1;
    mem_rdata = 64'h1111_2222_3333_4444;
    run_op(3'd1, 5'd4, 5'd8, 1'b0, 14'd2);
    check("ldu_wb_count", 64'(wb_cnt - b_wb), 64'd2);
    check("ldu_wb0", {59'd0, wb_reg[b_wb % 64]}, 64'd4);
    check("ldu_wb0_data", wb_dat[b_wb % 64], 64'h1111_2222_3333_4444);
    check("ldu_wb1", {59'd0, wb_reg[(b_wb + 1) % 64]}, 64'd8);
    check("ldu_wb1_data", wb_dat[(b_wb + 1) % 64], 64'h308);

    // Reset while a request is outstanding
    ack_delay = 20;
    issue(3'd0, 5'd3, 5'd4, 1'b0, 14'd2);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (memReq_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock_i);
    end
    check("rst_req_seen", 64'(seen), 64'd1);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    check("rst_ctrl", {stall_o, invalid_o, misaligned_o, rfReadEn_o, memReq_o, memWrite_o, wbEn_o}, 64'd0);
    check("rst_data", memAddr_o | memWData_o | wbData_o | {57'd0, rfReadAddr_o, memSize_o}, 64'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    ack_delay = 1;
    mem_rdata = 64'h1234;
    run_op(3'd0, 5'd3, 5'd4, 1'b0, 14'd2);
    check("post_rst_addr", mem_adr[b_mem % 64], 64'h1008);
    check("post_rst_wb", {wb_reg[b_wb % 64], wb_dat[b_wb % 64]}, {5'd3, 64'h1234});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
